mm_quote_engine: RTL
====================

// Module: mm_quote_engine
// PURPOSE
//  Parametrised front-running market-maker for the order book: samples book roots, quotes one tick
//  inside best non-bot bid/ask and pushes bot orders toward the engine's bot FIFO via valid/ready.
//  Adds spread guard, per-side open-quote limit, fill tracking, cooldown and freeze (dump) handling.
//  Sits in trading_system_top between ob_inst root outputs and the bot order FIFO write side.
// PARAMETERS
//  PRICE_W    16  price field width (order word = {price, is_buy, is_bot, qty})
//  QTY_W      14  quantity field width; PRICE_W+QTY_W+2 = 32
//  TICK        1  price improvement over the best non-bot level
//  QUOTE_QTY  10  qty carried on every bot order
//  MIN_SPREAD  2  minimum gap (ticks) required between a new quote and the opposite best
//  MAX_OPEN    4  max open bot quotes per side
//  COOLDOWN   16  clk_engine cycles waited after a quote pass before re-evaluating
//  CNT_W       4  width of open-quote counters; must hold MAX_OPEN
// PORTS
//  clk_engine         in   1   engine clock
//  rst_engine_n       in   1   asynchronous active-low reset
//  toggle_bot_enable  in   1   level from button sync; each rising edge flips enable
//  book_freeze        in   1   high while a dump runs; no new quote evaluation
//  bid_root           in  32   best bid word;  bid_present  in 1  bid heap non-empty
//  ask_root           in  32   best ask word;  ask_present  in 1  ask heap non-empty
//  fill_valid         in   1   trade event strobe;  fill_info  in 32  trade word (is_buy, is_bot used)
//  order_out          out 32   bot order word
//  order_valid        out  1   order_out valid
//  order_ready        in   1   bot FIFO accepts
//  bot_enabled        out  1   current enable state
//  open_bids          out CNT_W  open bot bid quotes;  open_asks  out CNT_W  open bot ask quotes
//  state_dbg          out  3   FSM state encoding
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, enable 0, counters 0, cooldown counter 0. Reset mid-SEND drops order_valid at once.
//  Toggle: registered previous level; rising edge flips enable. Disable does not retract a
//   presented order; SEND completes its handshake, then IDLE.
//  FSM: IDLE -> CHK_BID -> [SEND_BID] -> CHK_ASK -> [SEND_ASK] -> COOLDOWN -> IDLE.
//   IDLE: go CHK_BID when enable & !book_freeze.
//   CHK_BID: cand = bid_price+TICK (PRICE_W+1 bits). Issue if bid_present & !is_bot(bid_root) &
//    open_bids<MAX_OPEN & cand<=2^PRICE_W-1 & (!ask_present | ask_price-cand>=MIN_SPREAD,
//    signed compare). Else CHK_ASK.
//   CHK_ASK: cand = ask_price-TICK; needs ask_price>TICK, !is_bot(ask_root), open_asks<MAX_OPEN,
//    (!bid_present | cand-bid_price>=MIN_SPREAD). Roots re-sampled here, not reused from CHK_BID.
//   SEND_x: order_valid=1, order_out={cand, side, 1'b1, QUOTE_QTY} registered on entry; held
//    stable until order_valid&order_ready; then counter++ and next state. 1 cycle CHK->valid.
//   COOLDOWN: counts COOLDOWN cycles (lets bot orders reach heap roots), then IDLE.
//  book_freeze in CHK_x: go IDLE, no order. In SEND_x: no effect. In COOLDOWN: count continues.
//  Fills: fill_valid & is_bot(fill_info) decrements side selected by is_buy; saturates at 0.
//   Same-cycle handshake and fill on one side: counter unchanged. Counters never exceed MAX_OPEN.
// STRUCTURE
//  Shared header: order field macros PRICE/IS_BUY/IS_BOT/QTY and FSM state localparams.
//  Sub-module mm_side_counter (sat up/down, CNT_W, limit MAX_OPEN) instanced per side.
// TESTING
//  1 bid 90, ask 105 non-bot, toggle pulse -> order 91/buy/bot/10, then 104/sell/bot/10; opens 1/1.
//  2 after cooldown bid_root=92 non-bot -> single order 93/buy/bot; no ask order (root is bot 104).
//  3 bid 100 ask 102, MIN_SPREAD=2 -> no order_valid across 3 passes; counters stay 0.
//  4 order_ready low 20 cycles, freeze rises mid-SEND -> order_out stable, one handshake, then IDLE
//    with no CHK until freeze falls.
//  5 MAX_OPEN=2, non-bot bid kept best -> 2 bids then none; bot buy fill -> open_bids 1, next bid
//    issued; fill coincident with handshake -> count unchanged.
//  6 rst_engine_n low during SEND -> order_valid 0 same time, bot_enabled 0, state IDLE.

Source files
------------

// File: rtl/mm_quote_engine_pkg.sv
// Shared types for the market-maker quote engine: FSM state encoding and order-word field helpers.
// Order word layout is {price, is_buy, is_bot, qty}, so the flag bits sit just above the qty field.
package mm_quote_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHK_BID  = 3'd1,
        ST_SEND_BID = 3'd2,
        ST_CHK_ASK  = 3'd3,
        ST_SEND_ASK = 3'd4,
        ST_COOLDOWN = 3'd5
    } mm_state_t;

    function automatic logic order_is_bot(input logic [31:0] word, input int qty_w);
        return word[qty_w];
    endfunction

    function automatic logic order_is_buy(input logic [31:0] word, input int qty_w);
        return word[qty_w+1];
    endfunction

endpackage

// File: rtl/mm_side_counter.sv
// Saturating open-quote counter for one book side: +1 on accepted order, -1 on bot fill.
// Simultaneous increment and decrement cancel so the count never transiently overshoots.
module mm_side_counter #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 4
) (
    input  logic             clk_engine,
    input  logic             rst_engine_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    always_ff @(posedge clk_engine or negedge rst_engine_n) begin
        if (!rst_engine_n) begin
            count <= '0;
        end else if (inc && !dec && count < LIMIT_C) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mm_quote_engine.sv
// Front-running market maker: quotes one tick inside the best non-bot bid/ask and hands bot
// orders to the bot FIFO over valid/ready, with spread guard, open-quote limit and cooldown.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | waiting for enable and no book freeze
// ST_CHK_BID  | evaluate bid root for an improving buy quote
// ST_SEND_BID | present buy order until accepted
// ST_CHK_ASK  | evaluate ask root (freshly sampled) for an improving sell quote
// ST_SEND_ASK | present sell order until accepted
// ST_COOLDOWN | let bot orders reach the heap roots before re-evaluating
module mm_quote_engine
    import mm_quote_engine_pkg::*;
#(
    parameter int PRICE_W    = 16,
    parameter int QTY_W      = 14,
    parameter int TICK       = 1,
    parameter int QUOTE_QTY  = 10,
    parameter int MIN_SPREAD = 2,
    parameter int MAX_OPEN   = 4,
    parameter int COOLDOWN   = 16,
    parameter int CNT_W      = 4
) (
    input  logic             clk_engine,
    input  logic             rst_engine_n,
    input  logic             toggle_bot_enable,
    input  logic             book_freeze,
    input  logic [31:0]      bid_root,
    input  logic             bid_present,
    input  logic [31:0]      ask_root,
    input  logic             ask_present,
    input  logic             fill_valid,
    input  logic [31:0]      fill_info,
    output logic [31:0]      order_out,
    output logic             order_valid,
    input  logic             order_ready,
    output logic             bot_enabled,
    output logic [CNT_W-1:0] open_bids,
    output logic [CNT_W-1:0] open_asks,
    output logic [2:0]       state_dbg
);
    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CD_W-1:0]           CD_LOAD  = CD_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0]          MAX_C    = CNT_W'(MAX_OPEN);
    localparam logic [PRICE_W:0]          TICK_C   = (PRICE_W+1)'(TICK);
    localparam logic signed [PRICE_W+1:0] SPREAD_C = (PRICE_W+2)'(MIN_SPREAD);
    localparam logic [QTY_W-1:0]          QTY_C    = QTY_W'(QUOTE_QTY);

    mm_state_t       state, state_nx;
    logic [CD_W-1:0] cd_cnt;
    logic            toggle_prev;
    logic            ld_bid, ld_ask, cd_load, bid_inc, ask_inc;

    logic [PRICE_W-1:0]        bid_price, ask_price, ask_cand;
    logic [PRICE_W:0]          bid_cand;
    logic signed [PRICE_W+1:0] bid_gap, ask_gap;
    logic                      bid_ok, ask_ok;
    logic                      fill_bot, bid_dec, ask_dec;
    logic                      unused_bits;

    assign bid_price = bid_root[31 -: PRICE_W];
    assign ask_price = ask_root[31 -: PRICE_W];
    assign bid_cand  = {1'b0, bid_price} + TICK_C;
    assign ask_cand  = ask_price - TICK_C[PRICE_W-1:0];
    // Gaps are signed so a crossed or inverted book fails the spread guard instead of wrapping.
    assign bid_gap   = $signed({2'b00, ask_price}) - $signed({1'b0, bid_cand});
    assign ask_gap   = $signed({2'b00, ask_cand}) - $signed({2'b00, bid_price});

    assign bid_ok = bid_present && !order_is_bot(bid_root, QTY_W) && (open_bids < MAX_C)
                    && !bid_cand[PRICE_W] && (!ask_present || bid_gap >= SPREAD_C);
    assign ask_ok = ask_present && !order_is_bot(ask_root, QTY_W) && (open_asks < MAX_C)
                    && ({1'b0, ask_price} > TICK_C) && (!bid_present || ask_gap >= SPREAD_C);

    assign fill_bot = fill_valid && order_is_bot(fill_info, QTY_W);
    assign bid_dec  = fill_bot && order_is_buy(fill_info, QTY_W);
    assign ask_dec  = fill_bot && !order_is_buy(fill_info, QTY_W);

    assign unused_bits = ^{bid_root[QTY_W+1], bid_root[QTY_W-1:0], ask_root[QTY_W+1],
                           ask_root[QTY_W-1:0], fill_info[31:QTY_W+2], fill_info[QTY_W-1:0]};

    always_ff @(posedge clk_engine or negedge rst_engine_n) begin
        if (!rst_engine_n) begin
            toggle_prev <= 1'b0;
            bot_enabled <= 1'b0;
        end else begin
            toggle_prev <= toggle_bot_enable;
            if (toggle_bot_enable && !toggle_prev) bot_enabled <= !bot_enabled;
        end
    end

    always_ff @(posedge clk_engine or negedge rst_engine_n) begin
        if (!rst_engine_n) begin
            state     <= ST_IDLE;
            order_out <= '0;
            cd_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (ld_bid) order_out <= {bid_cand[PRICE_W-1:0], 1'b1, 1'b1, QTY_C};
            if (ld_ask) order_out <= {ask_cand, 1'b0, 1'b1, QTY_C};
            if (cd_load)                                  cd_cnt <= CD_LOAD;
            else if (state == ST_COOLDOWN && cd_cnt != '0) cd_cnt <= cd_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        ld_bid   = 1'b0;
        ld_ask   = 1'b0;
        cd_load  = 1'b0;
        bid_inc  = 1'b0;
        ask_inc  = 1'b0;
        case (state)
            ST_IDLE: if (bot_enabled && !book_freeze) state_nx = ST_CHK_BID;
            ST_CHK_BID: begin
                if (book_freeze || !bot_enabled) state_nx = ST_IDLE;
                else if (bid_ok) begin
                    state_nx = ST_SEND_BID;
                    ld_bid   = 1'b1;
                end else state_nx = ST_CHK_ASK;
            end
            ST_SEND_BID: if (order_ready) begin
                bid_inc  = 1'b1;
                state_nx = bot_enabled ? ST_CHK_ASK : ST_IDLE;
            end
            ST_CHK_ASK: begin
                if (book_freeze || !bot_enabled) state_nx = ST_IDLE;
                else if (ask_ok) begin
                    state_nx = ST_SEND_ASK;
                    ld_ask   = 1'b1;
                end else begin
                    state_nx = ST_COOLDOWN;
                    cd_load  = 1'b1;
                end
            end
            ST_SEND_ASK: if (order_ready) begin
                ask_inc = 1'b1;
                if (bot_enabled) begin
                    state_nx = ST_COOLDOWN;
                    cd_load  = 1'b1;
                end else state_nx = ST_IDLE;
            end
            ST_COOLDOWN: if (cd_cnt == '0) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign order_valid = (state == ST_SEND_BID) || (state == ST_SEND_ASK);
    assign state_dbg   = state;

    mm_side_counter #(.CNT_W(CNT_W), .LIMIT(MAX_OPEN)) u_bid_cnt (
        .clk_engine  (clk_engine),
        .rst_engine_n(rst_engine_n),
        .inc         (bid_inc),
        .dec         (bid_dec),
        .count       (open_bids)
    );

    mm_side_counter #(.CNT_W(CNT_W), .LIMIT(MAX_OPEN)) u_ask_cnt (
        .clk_engine  (clk_engine),
        .rst_engine_n(rst_engine_n),
        .inc         (ask_inc),
        .dec         (ask_dec),
        .count       (open_asks)
    );

endmodule
